// File: rtl/flt2fix_seq_if.sv
// Handshake/bus bundle between the batch sequencer, data memory, converter core and bench control.
interface flt2fix_seq_if;
    logic        start;
    logic        done;
    logic        busy;
    logic        err;
    logic [7:0]  dm_addr;
    logic [7:0]  dm_in;
    logic [7:0]  dm_out;
    logic        dm_wr;
    logic        cvt_start;
    logic [15:0] cvt_flt;
    logic        cvt_done;
    logic [15:0] cvt_fix;

    modport master (
        input  start, dm_out, cvt_done, cvt_fix,
        output done, busy, err, dm_addr, dm_in, dm_wr, cvt_start, cvt_flt
    );

    modport slave (
        output start, dm_out, cvt_done, cvt_fix,
        input  done, busy, err, dm_addr, dm_in, dm_wr, cvt_start, cvt_flt
    );
endinterface

// File: rtl/flt2fix_seq.sv
// Batch sequencer: reads float16 operands from data memory, runs each through the converter core
// and writes the 8.8 results back, pulsing done once per batch.
module flt2fix_seq #(
    parameter int unsigned NUM_WORDS = 1,
    parameter int unsigned SRC_BASE  = 4,
    parameter int unsigned DST_BASE  = 6,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          reset,
    flt2fix_seq_if.master bus
);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_LO, S_RD_HI, S_REQ, S_WAIT, S_WR_LO, S_WR_HI, S_DONE
    } state_t;

    state_t      r_state, w_state;
    logic        r_start_q;
    logic [6:0]  r_idx, w_idx;
    logic [7:0]  r_lo, w_lo;
    logic [15:0] r_res, w_res;
    logic [TW-1:0] r_tmo, w_tmo;
    logic        r_done, w_done;
    logic        r_busy, w_busy;
    logic        r_err, w_err;
    logic [7:0]  r_dm_addr, w_dm_addr;
    logic [7:0]  r_dm_in, w_dm_in;
    logic        r_dm_wr, w_dm_wr;
    logic        r_cvt_start, w_cvt_start;
    logic [15:0] r_cvt_flt, w_cvt_flt;
    logic [7:0]  w_src, w_dst;

    // Next-state logic; outputs are decoded from the next state so they register in step with it.
    always_comb begin
        w_state   = r_state;
        w_idx     = r_idx;
        w_lo      = r_lo;
        w_res     = r_res;
        w_tmo     = r_tmo;
        w_err     = r_err;
        w_cvt_flt = r_cvt_flt;
        w_dm_addr = r_dm_addr;
        w_dm_in   = r_dm_in;

        case (r_state)
            S_IDLE: begin
                if (r_start_q && !bus.start) begin
                    w_state = S_RD_LO;
                    w_err   = 1'b0;
                    w_idx   = 7'd0;
                end
            end
            S_RD_LO: begin
                w_lo    = bus.dm_out;
                w_state = S_RD_HI;
            end
            S_RD_HI: begin
                w_cvt_flt = {bus.dm_out, r_lo};
                w_state   = S_REQ;
            end
            S_REQ: begin
                w_tmo   = '0;
                w_state = S_WAIT;
            end
            S_WAIT: begin
                if (bus.cvt_done) begin
                    w_res   = bus.cvt_fix;
                    w_state = S_WR_LO;
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_res   = 16'h0000;
                    w_err   = 1'b1;
                    w_state = S_WR_LO;
                end else begin
                    w_tmo = r_tmo + TW'(1);
                end
            end
            S_WR_LO: w_state = S_WR_HI;
            S_WR_HI: begin
                w_idx   = r_idx + 7'd1;
                w_state = (r_idx == 7'(NUM_WORDS - 1)) ? S_DONE : S_RD_LO;
            end
            S_DONE: begin
                w_idx   = 7'd0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase

        w_src = 8'(SRC_BASE) + {w_idx, 1'b0};
        w_dst = 8'(DST_BASE) + {w_idx, 1'b0};
        case (w_state)
            S_RD_LO: w_dm_addr = w_src;
            S_RD_HI: w_dm_addr = r_dm_addr + 8'd1;
            S_WR_LO: begin
                w_dm_addr = w_dst;
                w_dm_in   = w_res[7:0];
            end
            S_WR_HI: begin
                w_dm_addr = r_dm_addr + 8'd1;
                w_dm_in   = w_res[15:8];
            end
            default: ;
        endcase

        w_dm_wr     = (w_state == S_WR_LO) || (w_state == S_WR_HI);
        w_cvt_start = (w_state == S_REQ);
        w_busy      = (w_state != S_IDLE);
        w_done      = (w_state == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            r_idx       <= 7'd0;
            r_lo        <= 8'd0;
            r_res       <= 16'd0;
            r_tmo       <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_dm_addr   <= 8'd0;
            r_dm_in     <= 8'd0;
            r_dm_wr     <= 1'b0;
            r_cvt_start <= 1'b0;
            r_cvt_flt   <= 16'd0;
        end else begin
            r_state     <= w_state;
            r_start_q   <= bus.start;
            r_idx       <= w_idx;
            r_lo        <= w_lo;
            r_res       <= w_res;
            r_tmo       <= w_tmo;
            r_done      <= w_done;
            r_busy      <= w_busy;
            r_err       <= w_err;
            r_dm_addr   <= w_dm_addr;
            r_dm_in     <= w_dm_in;
            r_dm_wr     <= w_dm_wr;
            r_cvt_start <= w_cvt_start;
            r_cvt_flt   <= w_cvt_flt;
        end
    end

    assign bus.done      = r_done;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
    assign bus.dm_addr   = r_dm_addr;
    assign bus.dm_in     = r_dm_in;
    assign bus.dm_wr     = r_dm_wr;
    assign bus.cvt_start = r_cvt_start;
    assign bus.cvt_flt   = r_cvt_flt;
endmodule

// File: tb/tb_flt2fix_seq.sv
// Bench for flt2fix_seq: a 1-word and a 4-word sequencer, each with its own memory and converter model.
module tb_flt2fix_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    flt2fix_seq_if b1();
    flt2fix_seq_if b4();

    flt2fix_seq #(.NUM_WORDS(1), .SRC_BASE(4), .DST_BASE(6), .TIMEOUT(64))
        u_dut1 (.clk(clk), .reset(reset), .bus(b1));
    flt2fix_seq #(.NUM_WORDS(4), .SRC_BASE(4), .DST_BASE(12), .TIMEOUT(64))
        u_dut4 (.clk(clk), .reset(reset), .bus(b4));

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  mem1 [256];
    logic [7:0]  mem4 [256];
    logic [15:0] log1[$], exp1[$], log4[$], exp4[$];
    int done1 = 0;
    int done4 = 0;

    assign b1.dm_out = mem1[b1.dm_addr];
    assign b4.dm_out = mem4[b4.dm_addr];

    // Memory writes and write/done logging.
    always @(posedge clk) begin
        if (b1.dm_wr === 1'b1) begin
            log1.push_back({b1.dm_addr, b1.dm_in});
            mem1[b1.dm_addr] = b1.dm_in;
        end
        if (b4.dm_wr === 1'b1) begin
            log4.push_back({b4.dm_addr, b4.dm_in});
            mem4[b4.dm_addr] = b4.dm_in;
        end
        if (b1.done === 1'b1) done1++;
        if (b4.done === 1'b1) done4++;
    end

    function automatic logic [15:0] f2x(input logic [15:0] f);
        int e;
        longint m;
        e = int'(f[14:10]);
        m = longint'({1'b1, f[9:0]});
        if (e == 0) m = 0;
        else if (e >= 17) m = m << (e - 17);
        else m = m >> (17 - e);
        if (e == 31 || m > 32767) m = 32767;
        return {f[15], 15'(m)};
    endfunction

    // Converter models: latency L from cvt_start cycle to cvt_done cycle, or never answer when hung.
    int lat1 = 3, lat4 = 3, cnt1 = 0, cnt4 = 0;
    bit hang1 = 0, hang4 = 0;
    logic cd1 = 1'b0, cd4 = 1'b0;
    logic [15:0] cf1 = 16'h0, cf4 = 16'h0, rs1 = 16'h0, rs4 = 16'h0;
    assign b1.cvt_done = cd1;
    assign b1.cvt_fix  = cf1;
    assign b4.cvt_done = cd4;
    assign b4.cvt_fix  = cf4;

    always @(posedge clk) begin
        cd1 <= 1'b0;
        if (cnt1 > 0) begin
            cnt1 <= cnt1 - 1;
            if (cnt1 == 1) begin cd1 <= 1'b1; cf1 <= rs1; end
        end
        if (b1.cvt_start === 1'b1 && !hang1) begin
            if (lat1 == 1) begin cd1 <= 1'b1; cf1 <= f2x(b1.cvt_flt); end
            else begin cnt1 <= lat1 - 1; rs1 <= f2x(b1.cvt_flt); end
        end
    end

    always @(posedge clk) begin
        cd4 <= 1'b0;
        if (cnt4 > 0) begin
            cnt4 <= cnt4 - 1;
            if (cnt4 == 1) begin cd4 <= 1'b1; cf4 <= rs4; end
        end
        if (b4.cvt_start === 1'b1 && !hang4) begin
            if (lat4 == 1) begin cd4 <= 1'b1; cf4 <= f2x(b4.cvt_flt); end
            else begin cnt4 <= lat4 - 1; rs4 <= f2x(b4.cvt_flt); end
        end
    end

    // Pulse start for one cycle; returns on the launch-detect edge.
    task automatic launch(input int sel);
        @(negedge clk);
        if (sel == 1) b1.start = 1'b1; else b4.start = 1'b1;
        @(negedge clk);
        if (sel == 1) b1.start = 1'b0; else b4.start = 1'b0;
        @(posedge clk);
    endtask

    // Counts cycles after the launch-detect edge until done is seen (bounded).
    task automatic wait_done(input int sel, output int cyc, output logic e1, output logic bz1);
        bit fin;
        logic d;
        fin = 0; cyc = 0; e1 = 1'bx; bz1 = 1'bx;
        while (!fin) begin
            #1;
            cyc++;
            if (cyc == 1) begin
                e1  = (sel == 1) ? b1.err  : b4.err;
                bz1 = (sel == 1) ? b1.busy : b4.busy;
            end
            d = (sel == 1) ? b1.done : b4.done;
            fin = (d === 1'b1) || (cyc >= 300);
            if (!fin) @(posedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        b1.start = 1'b0;
        b4.start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({b1.done, b1.busy, b1.err, b1.dm_wr, b1.cvt_start, b1.dm_addr, b1.dm_in, b1.cvt_flt} !== 45'd0) begin
            n_err++;
            $display("FAIL reset_dut1: outputs %h, expected 0",
                     {b1.done, b1.busy, b1.err, b1.dm_wr, b1.cvt_start, b1.dm_addr, b1.dm_in, b1.cvt_flt});
        end
        n_cmp++;
        if ({b4.done, b4.busy, b4.err, b4.dm_wr, b4.cvt_start, b4.dm_addr, b4.dm_in, b4.cvt_flt} !== 45'd0) begin
            n_err++;
            $display("FAIL reset_dut4: outputs %h, expected 0",
                     {b4.done, b4.busy, b4.err, b4.dm_wr, b4.cvt_start, b4.dm_addr, b4.dm_in, b4.cvt_flt});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int cyc, d0;
        logic e1, bz1;
        logic [15:0] e, o;
        lat1 = 3;
        mem1[4] = 8'h00; mem1[5] = 8'h3C;
        exp1.push_back({8'd6, 8'h00});
        exp1.push_back({8'd7, 8'h01});
        d0 = done1;
        launch(1);
        wait_done(1, cyc, e1, bz1);
        n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL single_done_cycle: got %0d want 9", cyc); end
        n_cmp++; if (bz1 !== 1'b1) begin n_err++; $display("FAIL single_busy_c1: got %b want 1", bz1); end
        n_cmp++; if (b1.busy !== 1'b1) begin n_err++; $display("FAIL single_busy_done: got %b want 1", b1.busy); end
        n_cmp++; if (b1.cvt_flt !== 16'h3C00) begin n_err++; $display("FAIL single_cvt_flt: got %h want 3c00", b1.cvt_flt); end
        n_cmp++; if (b1.err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", b1.err); end
        @(posedge clk); #1;
        n_cmp++; if ({b1.done, b1.busy} !== 2'b00) begin n_err++; $display("FAIL single_idle: done/busy %b want 00", {b1.done, b1.busy}); end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            o = (log1.size() > 0) ? log1.pop_front() : 16'hxxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL single_write: got %h want %h", o, e); end
        end
        n_cmp++; if (log1.size() != 0) begin n_err++; $display("FAIL single_extra_writes: got %0d want 0", log1.size()); log1.delete(); end
        n_cmp++; if (done1 - d0 !== 1) begin n_err++; $display("FAIL single_done_count: got %0d want 1", done1 - d0); end
    endtask

    task automatic test_batch;
        int cyc, d0;
        logic e1, bz1;
        logic [15:0] e, o;
        logic [15:0] ops [4];
        logic [15:0] res [4];
        ops = '{16'h3C00, 16'h4000, 16'hC200, 16'h7BFF};
        res = '{16'h0100, 16'h0200, 16'h8300, 16'h7FFF};
        lat4 = 3;
        for (int i = 0; i < 4; i++) begin
            mem4[4 + 2*i] = ops[i][7:0];
            mem4[5 + 2*i] = ops[i][15:8];
            exp4.push_back({8'(12 + 2*i), res[i][7:0]});
            exp4.push_back({8'(13 + 2*i), res[i][15:8]});
        end
        d0 = done4;
        launch(4);
        wait_done(4, cyc, e1, bz1);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL batch_done_cycle: got %0d want 33", cyc); end
        n_cmp++; if (bz1 !== 1'b1) begin n_err++; $display("FAIL batch_busy_c1: got %b want 1", bz1); end
        @(posedge clk); #1;
        while (exp4.size() > 0) begin
            e = exp4.pop_front();
            o = (log4.size() > 0) ? log4.pop_front() : 16'hxxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL batch_write: got %h want %h", o, e); end
        end
        n_cmp++; if (log4.size() != 0) begin n_err++; $display("FAIL batch_extra_writes: got %0d want 0", log4.size()); log4.delete(); end
        n_cmp++; if (done4 - d0 !== 1) begin n_err++; $display("FAIL batch_done_count: got %0d want 1", done4 - d0); end
    endtask

    task automatic test_timeout;
        int cyc;
        logic e1, bz1;
        logic [15:0] e, o;
        hang1 = 1;
        mem1[4] = 8'h00; mem1[5] = 8'h3C;
        exp1.push_back({8'd6, 8'h00});
        exp1.push_back({8'd7, 8'h00});
        launch(1);
        wait_done(1, cyc, e1, bz1);
        n_cmp++; if (cyc !== 70) begin n_err++; $display("FAIL timeout_done_cycle: got %0d want 70", cyc); end
        n_cmp++; if (b1.err !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %b want 1", b1.err); end
        @(posedge clk); #1;
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            o = (log1.size() > 0) ? log1.pop_front() : 16'hxxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL timeout_write: got %h want %h", o, e); end
        end
        n_cmp++; if (b1.err !== 1'b1) begin n_err++; $display("FAIL timeout_err_sticky: got %b want 1", b1.err); end
        hang1 = 0;
        exp1.push_back({8'd6, 8'h00});
        exp1.push_back({8'd7, 8'h01});
        launch(1);
        wait_done(1, cyc, e1, bz1);
        n_cmp++; if (e1 !== 1'b0) begin n_err++; $display("FAIL timeout_err_clear: got %b want 0", e1); end
        n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL timeout_relaunch_cycle: got %0d want 9", cyc); end
        @(posedge clk); #1;
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            o = (log1.size() > 0) ? log1.pop_front() : 16'hxxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL timeout_relaunch_write: got %h want %h", o, e); end
        end
        n_cmp++; if (log1.size() != 0) begin n_err++; $display("FAIL timeout_extra_writes: got %0d want 0", log1.size()); log1.delete(); end
    endtask

    task automatic test_start_ignored;
        int cyc, d0;
        logic e1, bz1;
        logic [15:0] e, o;
        logic [15:0] ops [4];
        logic [15:0] res [4];
        ops = '{16'h3800, 16'h4400, 16'hBC00, 16'h0000};
        res = '{16'h0080, 16'h0400, 16'h8100, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            mem4[4 + 2*i] = ops[i][7:0];
            mem4[5 + 2*i] = ops[i][15:8];
            exp4.push_back({8'(12 + 2*i), res[i][7:0]});
            exp4.push_back({8'(13 + 2*i), res[i][15:8]});
        end
        d0 = done4;
        launch(4);
        fork
            wait_done(4, cyc, e1, bz1);
            begin
                repeat (3) @(negedge clk);
                repeat (6) begin
                    @(negedge clk); b4.start = 1'b1;
                    @(negedge clk); b4.start = 1'b0;
                end
            end
        join
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL ignore_done_cycle: got %0d want 33", cyc); end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (done4 - d0 !== 1) begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", done4 - d0); end
        n_cmp++; if (b4.busy !== 1'b0) begin n_err++; $display("FAIL ignore_busy_after: got %b want 0", b4.busy); end
        while (exp4.size() > 0) begin
            e = exp4.pop_front();
            o = (log4.size() > 0) ? log4.pop_front() : 16'hxxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL ignore_write: got %h want %h", o, e); end
        end
        n_cmp++; if (log4.size() != 0) begin n_err++; $display("FAIL ignore_extra_writes: got %0d want 0", log4.size()); log4.delete(); end
    endtask

    task automatic test_reset_abort;
        int cyc, d0;
        logic e1, bz1;
        logic [15:0] e, o;
        bit hit;
        lat1 = 1;
        mem1[4] = 8'h00; mem1[5] = 8'h40;
        mem1[6] = 8'h5A; mem1[7] = 8'hA5;
        d0 = done1;
        hit = 0;
        launch(1);
        for (int k = 0; k < 40 && !hit; k++) begin
            @(posedge clk); #1;
            if (b1.dm_wr === 1'b1) hit = 1;
        end
        n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL abort_reach_wr_lo: got %b want 1", hit); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({b1.busy, b1.dm_wr} !== 2'b00) begin n_err++; $display("FAIL abort_drop: busy/dm_wr %b want 00", {b1.busy, b1.dm_wr}); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (mem1[7] !== 8'hA5) begin n_err++; $display("FAIL abort_mem7: got %h want a5", mem1[7]); end
        n_cmp++; if (log1.size() != 0) begin n_err++; $display("FAIL abort_writes: got %0d want 0", log1.size()); log1.delete(); end
        n_cmp++; if (done1 - d0 !== 0) begin n_err++; $display("FAIL abort_done: got %0d want 0", done1 - d0); end
        exp1.push_back({8'd6, 8'h00});
        exp1.push_back({8'd7, 8'h02});
        launch(1);
        wait_done(1, cyc, e1, bz1);
        n_cmp++; if (cyc !== 7) begin n_err++; $display("FAIL abort_relaunch_cycle: got %0d want 7", cyc); end
        @(posedge clk); #1;
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            o = (log1.size() > 0) ? log1.pop_front() : 16'hxxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL abort_relaunch_write: got %h want %h", o, e); end
        end
    endtask

    task automatic test_back_to_back;
        int cyc, d0;
        logic e1, bz1;
        logic [15:0] e, o;
        lat1 = 3;
        mem1[4] = 8'h00; mem1[5] = 8'h40;
        exp1.push_back({8'd6, 8'h00});
        exp1.push_back({8'd7, 8'h02});
        exp1.push_back({8'd6, 8'h00});
        exp1.push_back({8'd7, 8'h83});
        d0 = done1;
        launch(1);
        wait_done(1, cyc, e1, bz1);
        n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL b2b_first_cycle: got %0d want 9", cyc); end
        b1.start = 1'b1;
        mem1[4] = 8'h00; mem1[5] = 8'hC2;
        @(posedge clk); #1;
        b1.start = 1'b0;
        @(posedge clk);
        wait_done(1, cyc, e1, bz1);
        n_cmp++; if (bz1 !== 1'b1) begin n_err++; $display("FAIL b2b_second_launch: busy %b want 1", bz1); end
        n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL b2b_second_cycle: got %0d want 9", cyc); end
        @(posedge clk); #1;
        n_cmp++; if (done1 - d0 !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", done1 - d0); end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            o = (log1.size() > 0) ? log1.pop_front() : 16'hxxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL b2b_write: got %h want %h", o, e); end
        end
        n_cmp++; if (log1.size() != 0) begin n_err++; $display("FAIL b2b_extra_writes: got %0d want 0", log1.size()); log1.delete(); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 8'hEE;
            mem4[i] = 8'hEE;
        end
        test_reset();
        test_single();
        test_batch();
        test_timeout();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
